seq_gen_fsm: RTL and testbench
==============================

SEQ_GEN_FSM -- requirements
Module: seq_gen_fsm

Interface
REQ-001 Parameter: PAT_W, default 7, pattern length in bits.
REQ-002 Parameter: DEF_PAT, default 7'b1011010, pattern driven when use_def=1.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request; sampled only in IDLE.
REQ-006 Port: abort  input  1  synchronous cancel of the current burst.
REQ-007 Port: use_def  input  1  1 selects DEF_PAT, 0 selects pattern.
REQ-008 Port: pattern  input  PAT_W  user pattern, sent MSB first.
REQ-009 Port: rep_cnt  input  4  number of frames, 0..15.
REQ-010 Port: gap_len  input  3  number of 0 bits inserted between frames, 0..7.
REQ-011 Port: seq_out  output  1  serial data bit.
REQ-012 Port: seq_valid  output  1  seq_out is a stream bit this cycle.
REQ-013 Port: busy  output  1  burst in progress.
REQ-014 Port: done  output  1  one-cycle pulse at burst completion.

Function
REQ-015 The FSM SHALL have states IDLE, SEND and GAP; all outputs SHALL be registered.
REQ-016 In IDLE, when start=1 and rep_cnt!=0, the block SHALL latch the selected pattern, rep_cnt and gap_len into shadow registers and enter SEND; later input changes SHALL have no effect on the burst.
REQ-017 Latency: the first (MSB) bit SHALL appear on seq_out with seq_valid=1 in the cycle after start is sampled.
REQ-018 In SEND, the block SHALL output one pattern bit per cycle, MSB first, for PAT_W cycles, with seq_valid=1.
REQ-019 After the last bit of a frame:
  - if frames remain and gap_len>0: GAP;
  - if frames remain and gap_len=0: next frame back-to-back, no idle cycle;
  - if no frames remain: IDLE.
REQ-020 In GAP, the block SHALL output seq_out=0 with seq_valid=1 for exactly gap_len cycles, then return to SEND.
REQ-021 No gap SHALL follow the final frame.
REQ-022 busy SHALL be 1 from the first-bit cycle through the last-bit cycle inclusive, and 0 otherwise.
REQ-023 done SHALL pulse for 1 cycle in the cycle after the last bit, with busy=0 and seq_valid=0.
REQ-024 When start=1 and rep_cnt=0 in IDLE, no bits SHALL be sent, busy SHALL stay 0, and done SHALL pulse in the next cycle.
REQ-025 start while busy SHALL be ignored; it SHALL NOT be queued.
REQ-026 abort=1 in SEND or GAP SHALL force IDLE at the next edge: seq_valid=0, busy=0, no done pulse.
REQ-027 abort takes priority over start and over frame completion in the same cycle.
REQ-028 seq_out SHALL be 0 whenever seq_valid=0.
REQ-029 Burst length SHALL be rep_cnt*PAT_W + (rep_cnt-1)*gap_len cycles.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE; seq_out, seq_valid, busy and done =0; all counters and shadow registers =0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no done pulse.
REQ-032 After reset release, the block SHALL accept start on the first clock edge.

Structure
REQ-033 Package seq_gen_pkg SHALL hold the state encodings (IDLE=2'b00, SEND=2'b01, GAP=2'b10) and the DEF_PAT constant.
REQ-034 Sub-module seq_piso SHALL implement the PAT_W parallel-load, MSB-first shift register; frame, bit and gap counters SHALL stay in seq_gen_fsm.
REQ-035 The unused state encoding SHALL recover to IDLE.

Verification
REQ-036 use_def=1, rep_cnt=1, gap_len=0, start at cycle 0 -> seq_out 1,0,1,1,0,1,0 in cycles 1-7 with seq_valid=1; done=1 at cycle 8.
REQ-037 rep_cnt=2, gap_len=0, DEF_PAT -> 14 contiguous valid bits; the companion Mealy 1011010 detector fed seq_out (gated by seq_valid) flags exactly twice, at cycles 7 and 14.
REQ-038 rep_cnt=3, gap_len=2, pattern=7'b1110001, use_def=0 -> 25-cycle burst; cycles 8-9 and 17-18 are valid 0s; done at cycle 26.
REQ-039 rep_cnt=0 with start -> busy never rises, seq_valid stays 0, done=1 at cycle 1.
REQ-040 abort at cycle 4 of a 2-frame burst -> seq_valid=0 from cycle 5 and no done pulse; a new start at cycle 6 sends MSB at cycle 7.
REQ-041 rst_n low at cycle 3 -> all outputs 0 immediately; start pulses during busy are ignored.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared state encoding and default pattern for the serial sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int unsigned DEF_PAT_W = 7;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 7'b1011010;

endpackage

// File: rtl/seq_gen_fsm_piso.sv
// Parallel-load, MSB-first shift register; zeros shift in behind the pattern.
module seq_piso
    import seq_gen_pkg::*;
#(
    parameter int unsigned PAT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             ser
);

    logic [PAT_W-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (clear) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= din;
        end else if (shift) begin
            sr_q <= sr_q << 1;
        end
    end

    assign ser = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_gen_fsm.sv
// Burst generator: repeats a latched pattern rep_cnt times with zero-bit gaps.
module seq_gen_fsm
    import seq_gen_pkg::*;
#(
    parameter int unsigned      PAT_W   = 7,
    parameter logic [PAT_W-1:0] DEF_PAT = seq_gen_pkg::DEF_PAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       rep_cnt,
    input  logic [2:0]       gap_len,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt;
    logic [3:0]       frame_cnt;
    logic [2:0]       gap_cnt, gap_sh;
    logic [PAT_W-1:0] pat_sh, sel_pat, load_pat;
    logic             accept, last_bit, last_frame, gap_end;
    logic             piso_load, piso_clear, piso_shift;
    logic             valid_d, done_d;

    assign sel_pat    = use_def ? DEF_PAT : pattern;
    assign accept     = (state_q == IDLE) && start && !abort && (rep_cnt != 4'd0);
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign last_frame = (frame_cnt <= 4'd1);
    assign gap_end    = (gap_cnt == (gap_sh - 3'd1));
    assign load_pat   = (state_q == IDLE) ? sel_pat : pat_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        piso_load  = 1'b0;
        piso_clear = 1'b0;
        piso_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SEND;
                    piso_load = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d    = IDLE;
                    piso_clear = 1'b1;
                end else if (last_bit) begin
                    if (last_frame) begin
                        state_d    = IDLE;
                        piso_shift = 1'b1;
                    end else if (gap_sh != 3'd0) begin
                        state_d    = GAP;
                        piso_shift = 1'b1;
                    end else begin
                        piso_load = 1'b1;
                    end
                end else begin
                    piso_shift = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d    = IDLE;
                    piso_clear = 1'b1;
                end else if (gap_end) begin
                    state_d   = SEND;
                    piso_load = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                piso_clear = 1'b1;
            end
        endcase
    end

    always_comb begin
        valid_d = (state_d == SEND) || (state_d == GAP);
        done_d  = 1'b0;
        if ((state_q == IDLE) && start && !abort && (rep_cnt == 4'd0)) begin
            done_d = 1'b1;
        end
        if ((state_q == SEND) && !abort && last_bit && last_frame) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            seq_valid <= valid_d;
            busy      <= valid_d;
            done      <= done_d;
        end
    end

    // bit_cnt restarts on every frame load; frame_cnt counts frames still to finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_sh    <= '0;
            frame_cnt <= '0;
            gap_sh    <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            if (accept) begin
                pat_sh    <= sel_pat;
                frame_cnt <= rep_cnt;
                gap_sh    <= gap_len;
            end else if ((state_q == SEND) && last_bit && !abort) begin
                frame_cnt <= frame_cnt - 4'd1;
            end
            bit_cnt <= ((state_q == SEND) && (state_d == SEND) && !piso_load) ? bit_cnt + 1'b1 : '0;
            gap_cnt <= ((state_q == GAP) && (state_d == GAP)) ? gap_cnt + 3'd1 : '0;
        end
    end

    seq_piso #(
        .PAT_W(PAT_W)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (piso_load),
        .clear(piso_clear),
        .shift(piso_shift),
        .din  (load_pat),
        .ser  (seq_out)
    );

endmodule

// File: tb/tb_seq_gen_fsm.sv
// Table-driven scoreboard bench for seq_gen_fsm plus hand-written corner sequences.
module tb_seq_gen_fsm;

    localparam int unsigned PAT_W = 7;
    localparam logic [6:0]  DPAT  = 7'b1011010;

    logic             clk = 1'b0;
    logic             rst_n, start, abort, use_def;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       rep_cnt;
    logic [2:0]       gap_len;
    logic             seq_out, seq_valid, busy, done;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic so;
        logic sv;
        logic bz;
        logic dn;
    } obs_t;

    typedef struct {
        logic       ud;
        logic [6:0] pat;
        logic [3:0] rep;
        logic [2:0] gap;
        int         abort_at;
        int         noise_at;
        int         exp_busy;
    } vec_t;

    vec_t vecs[10];
    obs_t exp_q[$];

    seq_gen_fsm #(
        .PAT_W  (PAT_W),
        .DEF_PAT(DPAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .use_def  (use_def),
        .pattern  (pattern),
        .rep_cnt  (rep_cnt),
        .gap_len  (gap_len),
        .seq_out  (seq_out),
        .seq_valid(seq_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return {seq_out, seq_valid, busy, done};
    endfunction

    task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got(out,valid,busy,done)=%b required=%b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Independent model: frames MSB first, gaps only between frames, done after last bit.
    function automatic void build_expected(input vec_t v);
        logic [6:0] p;
        p = v.ud ? DPAT : v.pat;
        exp_q.delete();
        for (int f = 0; f < int'(v.rep); f++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
            if (f < int'(v.rep) - 1)
                for (int g = 0; g < int'(v.gap); g++) exp_q.push_back(4'b0110);
        end
        if (v.abort_at > 0 && v.abort_at <= exp_q.size()) begin
            while (exp_q.size() > v.abort_at) void'(exp_q.pop_back());
            repeat (3) exp_q.push_back(4'b0000);
        end else begin
            exp_q.push_back(4'b0001);
            repeat (2) exp_q.push_back(4'b0000);
        end
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc;
        int   busy_seen;
        obs_t e;
        v         = vecs[idx];
        cyc       = 0;
        busy_seen = 0;
        build_expected(v);
        @(posedge clk); #1;
        use_def = v.ud; pattern = v.pat; rep_cnt = v.rep; gap_len = v.gap;
        start = 1'b1; abort = 1'b0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == v.noise_at);
            if (cyc == v.noise_at) begin
                use_def = ~use_def; pattern = ~pattern; rep_cnt = 4'd9; gap_len = gap_len + 3'd3;
            end
            abort = (cyc == v.abort_at);
            @(negedge clk);
            e = exp_q.pop_front();
            if (busy) busy_seen++;
            check($sformatf("vec%0d", idx), cyc, cur(), e);
        end
        start = 1'b0; abort = 1'b0;
        check_int($sformatf("vec%0d_burst_len", idx), busy_seen, v.exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] hist;
        int         nvalid;
        int         flags[$];

        vecs[0] = '{1'b1, 7'b0000000, 4'd1,  3'd0, 0, 0, 7};
        vecs[1] = '{1'b1, 7'b0000000, 4'd2,  3'd0, 0, 0, 14};
        vecs[2] = '{1'b0, 7'b1110001, 4'd3,  3'd2, 0, 0, 25};
        vecs[3] = '{1'b1, 7'b0000000, 4'd0,  3'd3, 0, 0, 0};
        vecs[4] = '{1'b1, 7'b0000000, 4'd2,  3'd3, 4, 0, 4};
        vecs[5] = '{1'b0, 7'b0000001, 4'd15, 3'd7, 0, 0, 203};
        vecs[6] = '{1'b0, 7'b1000000, 4'd1,  3'd5, 0, 0, 7};
        vecs[7] = '{1'b0, 7'b1100101, 4'd2,  3'd1, 0, 3, 15};
        vecs[8] = '{1'b1, 7'b0000000, 4'd1,  3'd0, 7, 0, 7};
        vecs[9] = '{1'b0, 7'b1010101, 4'd2,  3'd2, 8, 0, 8};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; use_def = 1'b0;
        pattern = '0; rep_cnt = '0; gap_len = '0;
        #12;
        check("reset_state", 0, cur(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Overlapping 1011010 detector on the valid stream of a 2-frame back-to-back burst.
        @(posedge clk); #1;
        use_def = 1'b1; rep_cnt = 4'd2; gap_len = 3'd0; start = 1'b1;
        hist = '0; nvalid = 0; flags.delete();
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            if (seq_valid) begin
                hist = {hist[5:0], seq_out};
                nvalid++;
                if (nvalid >= 7 && hist == DPAT) flags.push_back(c);
            end
        end
        check_int("detect_count", flags.size(), 2);
        check_int("detect_first", (flags.size() > 0) ? flags[0] : -1, 7);
        check_int("detect_second", (flags.size() > 1) ? flags[1] : -1, 14);

        // Abort at cycle 4, restart at cycle 6; the aborted burst must leave no trace.
        @(posedge clk); #1;
        use_def = 1'b1; rep_cnt = 4'd2; gap_len = 3'd1; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            abort = (c == 4);
            start = (c == 6);
            if (c == 6) rep_cnt = 4'd1;
            @(negedge clk);
            if (c == 4) check("abort_last_bit", c, cur(), 4'b1110);
            if (c == 5 || c == 6) check("abort_idle", c, cur(), 4'b0000);
            if (c == 7) check("restart_msb", c, cur(), 4'b1110);
            if (c == 14) check("restart_done", c, cur(), 4'b0001);
            if (c == 15) check("restart_after", c, cur(), 4'b0000);
        end

        // Start together with abort in IDLE: abort wins, nothing happens.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; rep_cnt = 4'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_over_start", 1, cur(), 4'b0000);
        @(negedge clk);
        check("abort_over_start", 2, cur(), 4'b0000);

        // Reset mid-burst with a start pulse while busy, then start on the first edge after release.
        @(posedge clk); #1;
        use_def = 1'b1; rep_cnt = 4'd3; gap_len = 3'd2; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = (c == 2);
        end
        rst_n = 1'b0;
        #1;
        check("async_reset", 3, cur(), 4'b0000);
        @(negedge clk);
        check("reset_held", 3, cur(), 4'b0000);
        rst_n = 1'b1; rep_cnt = 4'd1; gap_len = 3'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 7) check("post_reset", c, cur(), {DPAT[7 - c], 3'b110});
            else if (c == 8) check("post_reset_done", c, cur(), 4'b0001);
            else check("post_reset_idle", c, cur(), 4'b0000);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
